// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register IDs and data width.
package y86_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_ids_t;

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file: three async read ports, two write ports.
// When both write ports target one register, the M port wins.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int                DW        = DATA_W,
  parameter logic [DW-1:0]     RSP_RESET = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    ra_sel_i,
  input  logic [3:0]    rb_sel_i,
  input  logic [3:0]    dbg_sel_i,
  output logic [DW-1:0] ra_val_o,
  output logic [DW-1:0] rb_val_o,
  output logic [DW-1:0] dbg_val_o,
  input  logic          we_i,
  input  logic [3:0]    we_e_sel_i,
  input  logic [DW-1:0] we_e_val_i,
  input  logic [3:0]    we_m_sel_i,
  input  logic [DW-1:0] we_m_val_i
);

  logic [DW-1:0] regs_q [15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++)
        regs_q[i] <= (i == int'(RSP)) ? RSP_RESET : '0;
    end else if (we_i) begin
      if (we_e_sel_i != RNONE)
        regs_q[we_e_sel_i] <= we_e_val_i;
      // Later assignment gives the M port priority on a collision.
      if (we_m_sel_i != RNONE)
        regs_q[we_m_sel_i] <= we_m_val_i;
    end
  end

  always_comb begin
    ra_val_o  = '0;
    rb_val_o  = '0;
    dbg_val_o = '0;
    if (ra_sel_i != RNONE)
      ra_val_o = regs_q[ra_sel_i];
    if (rb_sel_i != RNONE)
      rb_val_o = regs_q[rb_sel_i];
    if (dbg_sel_i != RNONE)
      dbg_val_o = regs_q[dbg_sel_i];
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back: register ID decode plus the register file.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int                    DATA_W    = y86_pkg::DATA_W,
  parameter logic [DATA_W-1:0]     RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              wb_en,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  dec_ids_t ids;

  always_comb begin
    ids = '{src_a: RNONE, src_b: RNONE,
            dst_e: RNONE, dst_m: RNONE};
    unique case (icode)
      I_RRMOVQ: begin
        ids.src_a = rA;
        ids.dst_e = cnd ? rB : RNONE;
      end
      I_IRMOVQ: ids.dst_e = rB;
      I_RMMOVQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
      end
      I_MRMOVQ: begin
        ids.src_b = rB;
        ids.dst_m = rA;
      end
      I_OPQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
        ids.dst_e = rB;
      end
      I_CALL: begin
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_RET: begin
        ids.src_a = RSP;
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_PUSHQ: begin
        ids.src_a = rA;
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_POPQ: begin
        ids.src_a = RSP;
        ids.src_b = RSP;
        ids.dst_e = RSP;
        ids.dst_m = rA;
      end
      default: ;
    endcase
  end

  assign srcA = ids.src_a;
  assign srcB = ids.src_b;
  assign dstE = ids.dst_e;
  assign dstM = ids.dst_m;

  y86_regfile #(
    .DW        (DATA_W),
    .RSP_RESET (RSP_RESET)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .ra_sel_i   (ids.src_a),
    .rb_sel_i   (ids.src_b),
    .dbg_sel_i  (dbg_sel),
    .ra_val_o   (valA),
    .rb_val_o   (valB),
    .dbg_val_o  (dbg_val),
    .we_i       (wb_en),
    .we_e_sel_i (ids.dst_e),
    .we_e_val_i (valE),
    .we_m_sel_i (ids.dst_m),
    .we_m_val_i (valM)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback with a queue of expected results.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, rA, rB, dbg_sel;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, dbg_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_writeback #(
    .DATA_W    (64),
    .RSP_RESET (64'h200)
  ) dut (
    .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .wb_en(wb_en),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  task automatic expect_v(input string tag, input logic [63:0] v);
    sb.push_back('{tag: tag, val: v});
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_ids(input string t, input logic [3:0] a, b, e, m);
    expect_v({t, "_srcA"}, {60'd0, a}); check({60'd0, srcA});
    expect_v({t, "_srcB"}, {60'd0, b}); check({60'd0, srcB});
    expect_v({t, "_dstE"}, {60'd0, e}); check({60'd0, dstE});
    expect_v({t, "_dstM"}, {60'd0, m}); check({60'd0, dstM});
  endtask

  task automatic chk_reg(input string t, input logic [3:0] r,
                         input logic [63:0] v);
    dbg_sel = r;
    #1;
    expect_v(t, v);
    check(dbg_val);
  endtask

  task automatic drive(input logic [3:0] ic, a, b, input logic c,
                       input logic [63:0] e, m, input logic we);
    icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m; wb_en = we;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dbg_sel = 4'h0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);

    // 1. Reset contents
    for (int i = 0; i < 15; i++)
      chk_reg($sformatf("rst_R%0d", i), 4'(i),
              (i == 4) ? 64'h200 : 64'd0);
    chk_reg("rst_dbgF", 4'hF, 64'd0);
    expect_v("nop_valA", 64'd0); check(valA);
    expect_v("nop_valB", 64'd0); check(valB);
    chk_ids("nop", 4'hF, 4'hF, 4'hF, 4'hF);
    edge_step();
    rst = 1'b0;
    #1;

    // 2. irmovq then OPq reads it back
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'd0, 1'b1);
    chk_ids("irmovq", 4'hF, 4'hF, 4'h2, 4'hF);
    chk_reg("irmovq_pre_R2", 4'h2, 64'd0);
    edge_step();
    chk_reg("irmovq_R2", 4'h2, 64'h1234);
    drive(4'h6, 4'h2, 4'h2, 1'b0, 64'h0, 64'd0, 1'b0);
    expect_v("opq_valA", 64'h1234); check(valA);
    expect_v("opq_valB", 64'h1234); check(valB);
    chk_ids("opq", 4'h2, 4'h2, 4'h2, 4'hF);

    // 3. cmovXX with cnd 0 then 1
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'hAAAA, 64'd0, 1'b1);
    chk_ids("cmov0", 4'h1, 4'hF, 4'hF, 4'hF);
    edge_step();
    chk_reg("cmov0_R3", 4'h3, 64'd0);
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'hBBBB, 64'd0, 1'b1);
    chk_ids("cmov1", 4'h1, 4'hF, 4'h3, 4'hF);
    edge_step();
    chk_reg("cmov1_R3", 4'h3, 64'hBBBB);

    // 4. popq %rsp: M port wins
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hBEEF, 1'b1);
    chk_ids("popq", 4'h4, 4'h4, 4'h4, 4'h4);
    expect_v("popq_valA", 64'h200); check(valA);
    edge_step();
    chk_reg("popq_R4", 4'h4, 64'hBEEF);

    // 5. pushq / call / ret update %rsp with valE
    drive(4'hA, 4'h2, 4'hF, 1'b0, 64'h1F8, 64'd0, 1'b1);
    chk_ids("pushq", 4'h2, 4'h4, 4'h4, 4'hF);
    expect_v("pushq_valA", 64'h1234); check(valA);
    expect_v("pushq_valB", 64'hBEEF); check(valB);
    edge_step();
    chk_reg("pushq_R4", 4'h4, 64'h1F8);
    drive(4'h8, 4'hF, 4'hF, 1'b0, 64'h1F0, 64'd0, 1'b1);
    chk_ids("call", 4'hF, 4'h4, 4'h4, 4'hF);
    edge_step();
    chk_reg("call_R4", 4'h4, 64'h1F0);
    drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h1F8, 64'd0, 1'b1);
    chk_ids("ret", 4'h4, 4'h4, 4'h4, 4'hF);
    edge_step();
    chk_reg("ret_R4", 4'h4, 64'h1F8);

    // wb_en low: halt, then an OPq blocked by an imem error
    drive(4'h0, 4'h2, 4'h2, 1'b1, 64'hDEAD, 64'hDEAD, 1'b0);
    chk_ids("halt", 4'hF, 4'hF, 4'hF, 4'hF);
    edge_step();
    drive(4'h6, 4'h2, 4'h2, 1'b0, 64'hDEAD, 64'hDEAD, 1'b0);
    chk_ids("opq_noen", 4'h2, 4'h2, 4'h2, 4'hF);
    edge_step();
    chk_reg("noen_R2", 4'h2, 64'h1234);
    chk_reg("noen_R4", 4'h4, 64'h1F8);
    drive(4'hC, 4'h2, 4'h2, 1'b1, 64'hDEAD, 64'hDEAD, 1'b1);
    chk_ids("invalid", 4'hF, 4'hF, 4'hF, 4'hF);
    edge_step();
    chk_reg("invalid_R2", 4'h2, 64'h1234);

    // 6. Async reset mid-instruction
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'd0, 1'b1);
    edge_step();
    chk_reg("pre_rst_R5", 4'h5, 64'h55);
    drive(4'h5, 4'h5, 4'h1, 1'b0, 64'd0, 64'h77, 1'b1);
    chk_ids("mrmovq", 4'hF, 4'h1, 4'hF, 4'h5);
    rst = 1'b1;
    #1;
    chk_reg("async_R5", 4'h5, 64'd0);
    chk_reg("async_R4", 4'h4, 64'h200);
    edge_step();
    chk_reg("rst_edge_R5", 4'h5, 64'd0);
    wb_en = 1'b0;
    rst = 1'b0;
    #1;
    chk_reg("post_rst_R5", 4'h5, 64'd0);
    chk_reg("post_rst_R2", 4'h2, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
